// File: rtl/adder_seq_pkg.sv
// Shared definitions for the seven-bit serial add sequencer: state codes and
// the adder width.
package adder_seq_pkg;

    typedef enum logic [2:0] {
        ST_LA0  = 3'd0,
        ST_LA1  = 3'd1,
        ST_LB0  = 3'd2,
        ST_LB1  = 3'd3,
        ST_ADD  = 3'd4,
        ST_SHOW = 3'd5
    } state_t;

    localparam int unsigned ADD_BITS = 7;
    localparam logic [2:0]  LAST_BIT = 3'(ADD_BITS - 1);

endpackage

// File: rtl/full_adder.sv
// One-bit full adder used by the bit-serial add datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/pb_debounce.sv
// Pushbutton conditioning: two-flop synchronizer, consecutive-sample debounce
// and a registered one-cycle pulse on each debounced rising edge.
module pb_debounce #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic pb,
    output logic press
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic          sync1_r;
    logic          sync2_r;
    logic          level_r;
    logic          press_r;
    logic [CW-1:0] cnt_r;

    // Synchronize, count samples that disagree with the accepted level, and
    // flag the cycle in which a new high level is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            level_r <= 1'b0;
            press_r <= 1'b0;
            cnt_r   <= '0;
        end else begin
            sync1_r <= pb;
            sync2_r <= sync1_r;
            press_r <= 1'b0;
            if (sync2_r == level_r) begin
                cnt_r <= '0;
            end else if (cnt_r == CNT_MAX) begin
                level_r <= sync2_r;
                press_r <= sync2_r;
                cnt_r   <= '0;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

    assign press = press_r;

endmodule

// File: rtl/seven_bit_add_sequencer.sv
// Loads two 7-bit operands nibble-by-nibble on debounced button presses, adds
// them bit-serially through one full adder, and shows the registered result.
module seven_bit_add_sequencer
    import adder_seq_pkg::*;
#(
    parameter int DB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pb,
    input  logic [3:0] sw,
    output logic [6:0] z,
    output logic       carry,
    output logic [2:0] phase,
    output logic       busy,
    output logic       done
);

    state_t     state_r;
    state_t     state_s;
    logic       press_s;
    logic [6:0] a_r;
    logic [6:0] b_r;
    logic [6:0] z_r;
    logic       carry_r;
    logic       c_r;
    logic [2:0] idx_r;
    logic       fa_sum_s;
    logic       fa_cout_s;

    pb_debounce #(.DB_CYCLES(DB_CYCLES)) u_debounce (
        .clk   (clk),
        .rst   (rst),
        .pb    (pb),
        .press (press_s)
    );

    full_adder u_fa (
        .a    (a_r[idx_r]),
        .b    (b_r[idx_r]),
        .cin  (c_r),
        .s    (fa_sum_s),
        .cout (fa_cout_s)
    );

    // Next-state decode; ADD ignores presses, unused codes fall back to LA0.
    always_comb begin
        state_s = ST_LA0;
        case (state_r)
            ST_LA0:  if (press_s) state_s = ST_LA1;  else state_s = ST_LA0;
            ST_LA1:  if (press_s) state_s = ST_LB0;  else state_s = ST_LA1;
            ST_LB0:  if (press_s) state_s = ST_LB1;  else state_s = ST_LB0;
            ST_LB1:  if (press_s) state_s = ST_ADD;  else state_s = ST_LB1;
            ST_ADD:  if (idx_r == LAST_BIT) state_s = ST_SHOW; else state_s = ST_ADD;
            ST_SHOW: if (press_s) state_s = ST_LA0;  else state_s = ST_SHOW;
            default: state_s = ST_LA0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_LA0;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand loading and the serial add; the result is cleared on ADD entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r     <= 7'd0;
            b_r     <= 7'd0;
            z_r     <= 7'd0;
            carry_r <= 1'b0;
            c_r     <= 1'b0;
            idx_r   <= 3'd0;
        end else begin
            case (state_r)
                ST_LA0: if (press_s) a_r[3:0] <= sw;
                ST_LA1: if (press_s) a_r[6:4] <= sw[2:0];
                ST_LB0: if (press_s) b_r[3:0] <= sw;
                ST_LB1: begin
                    if (press_s) begin
                        b_r[6:4] <= sw[2:0];
                        idx_r    <= 3'd0;
                        c_r      <= 1'b0;
                        z_r      <= 7'd0;
                        carry_r  <= 1'b0;
                    end
                end
                ST_ADD: begin
                    z_r[idx_r] <= fa_sum_s;
                    c_r        <= fa_cout_s;
                    idx_r      <= idx_r + 3'd1;
                    if (idx_r == LAST_BIT) carry_r <= fa_cout_s;
                end
                default: begin
                end
            endcase
        end
    end

    assign z     = z_r;
    assign carry = carry_r;
    assign phase = state_r;
    assign busy  = (state_r == ST_ADD);
    assign done  = (state_r == ST_SHOW);

endmodule
